// File: rtl/div32_q8.sv
// Sequential unsigned fixed-point divider: quotient = (dividend * 2^FRAC) / divisor,
// radix-2 restoring, one quotient bit per clock, start/done handshake.
module div32_q8 #(
    parameter int DW   = 32,
    parameter int VW   = 16,
    parameter int FRAC = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [VW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          ovf,
    output logic          dbz,
    output logic [1:0]    dbg_state
);

    // Handshake: start is sampled only in IDLE; done pulses for one cycle and the
    // result outputs stay valid from that cycle until the next done or reset.

    localparam int NW = DW + FRAC;
    localparam int CW = $clog2(NW + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t        r_state;
    logic [NW-1:0] r_num;
    logic [NW-1:0] r_quo;
    logic [VW-1:0] r_den;
    logic [VW-1:0] r_rem;
    logic [CW-1:0] r_cnt;
    logic          r_dbz_pend;

    logic          r_busy;
    logic          r_done;
    logic [VW-1:0] r_quotient;
    logic [VW-1:0] r_remainder;
    logic          r_ovf;
    logic          r_dbz;

    logic [VW:0]   w_rem_shift;
    logic          w_ge;
    logic [VW-1:0] w_rem_sub;
    logic          w_last;
    logic          w_ovf;

    // The partial remainder only needs VW+1 bits while shifted; after the
    // conditional subtract it is always below D, so VW bits hold it.
    assign w_rem_shift = {r_rem, r_num[NW-1]};
    assign w_ge        = (w_rem_shift >= {1'b0, r_den});
    assign w_rem_sub   = w_rem_shift[VW-1:0] - r_den;
    assign w_last      = (r_cnt == CW'(NW - 1));
    assign w_ovf       = |r_quo[NW-1:VW];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_num       <= '0;
            r_quo       <= '0;
            r_den       <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
            r_dbz_pend  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_ovf       <= 1'b0;
            r_dbz       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            r_dbz_pend <= 1'b1;
                            r_state    <= S_FIN;
                        end else begin
                            r_num      <= {dividend, {FRAC{1'b0}}};
                            r_den      <= divisor;
                            r_rem      <= '0;
                            r_quo      <= '0;
                            r_cnt      <= '0;
                            r_dbz_pend <= 1'b0;
                            r_busy     <= 1'b1;
                            r_state    <= S_CALC;
                        end
                    end
                end

                S_CALC: begin
                    r_rem <= w_ge ? w_rem_sub : w_rem_shift[VW-1:0];
                    r_quo <= {r_quo[NW-2:0], w_ge};
                    r_num <= {r_num[NW-2:0], 1'b0};
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_busy  <= 1'b0;
                        r_state <= S_FIN;
                    end
                end

                S_FIN: begin
                    if (r_dbz_pend) begin
                        r_quotient  <= '1;
                        r_remainder <= '0;
                        r_ovf       <= 1'b0;
                        r_dbz       <= 1'b1;
                    end else begin
                        r_quotient  <= w_ovf ? {VW{1'b1}} : r_quo[VW-1:0];
                        r_remainder <= r_rem;
                        r_ovf       <= w_ovf;
                        r_dbz       <= 1'b0;
                    end
                    r_dbz_pend <= 1'b0;
                    r_done     <= 1'b1;
                    r_state    <= S_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign quotient  = r_quotient;
    assign remainder = r_remainder;
    assign ovf       = r_ovf;
    assign dbz       = r_dbz;
    assign dbg_state = r_state;

endmodule
